// File: rtl/view_ctrl.sv
// View configuration controller: button presses queue scale/mirror requests that commit at the frame boundary.
// Optional automatic scale stepping every DEMO_FRAMES frames when DEMO_CYCLE_EN is defined.
module view_ctrl #(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int DEMO_FRAMES = 120
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btn_scale_in,
  input  logic        btn_mirror_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [1:0]  scale_out,
  output logic        mirror_out,
  output logic        in_frame_out,
  output logic        commit_out
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

  state_t      state, state_nxt;
  logic        scale_prev, mirror_prev;
  logic        scale_press, mirror_press, any_press;
  logic        boundary, demo_force, commit, pend_differs;
  logic [1:0]  pend_scale, pend_scale_nxt;
  logic        pend_mirror, pend_mirror_nxt;
  logic [10:0] h_lim;
  logic [9:0]  v_lim;
  logic        win_comb, win_p0;

  function automatic logic [1:0] scale_step(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign boundary     = (hcount_in == 11'd0) && (vcount_in == V_LIM);
  assign scale_press  = (btn_scale_in & ~scale_prev) | demo_force;
  assign mirror_press = btn_mirror_in & ~mirror_prev;
  assign any_press    = scale_press | mirror_press;
  assign pend_differs = (pend_scale != scale_out) || (pend_mirror != mirror_out);

  assign pend_scale_nxt  = scale_press ? scale_step(pend_scale) : pend_scale;
  assign pend_mirror_nxt = mirror_press ? ~pend_mirror : pend_mirror;

`ifdef DEMO_CYCLE_EN
  localparam logic [15:0] DEMO_LAST = 16'(DEMO_FRAMES - 1);
  logic [15:0] frame_cnt;

  // The forced step is OR-ed with the button, so a coincident real press is still one step.
  assign demo_force = boundary && (frame_cnt == DEMO_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt <= 16'd0;
    end else if (boundary) begin
      frame_cnt <= demo_force ? 16'd0 : frame_cnt + 16'd1;
    end
  end
`else
  // No automatic stepping in this build; DEMO_FRAMES only keeps the parameter list uniform.
  assign demo_force = 1'b0 && (DEMO_FRAMES > 0);
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // A press on the boundary cycle is never part of that commit: it keeps the FSM pending.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_press) state_nxt = PENDING;
      PENDING: if (boundary || !pend_differs) state_nxt = any_press ? PENDING : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    commit = (state == PENDING) && boundary && pend_differs;
  end

  always_comb begin
    h_lim = 11'd640;
    v_lim = 10'd768;
    case (scale_out)
      2'd0:    begin h_lim = 11'd240; v_lim = 10'd320; end
      2'd1:    begin h_lim = 11'd480; v_lim = 10'd640; end
      default: begin h_lim = 11'd640; v_lim = 10'd768; end
    endcase
    win_comb = (hcount_in < H_LIM) && (vcount_in < V_LIM) &&
               (hcount_in < h_lim) && (vcount_in < v_lim);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      scale_prev   <= 1'b0;
      mirror_prev  <= 1'b0;
      pend_scale   <= 2'd0;
      pend_mirror  <= 1'b0;
      scale_out    <= 2'd0;
      mirror_out   <= 1'b0;
      commit_out   <= 1'b0;
      win_p0       <= 1'b0;
      in_frame_out <= 1'b0;
    end else begin
      scale_prev  <= btn_scale_in;
      mirror_prev <= btn_mirror_in;
      pend_scale  <= pend_scale_nxt;
      pend_mirror <= pend_mirror_nxt;
      commit_out  <= commit;
      if (commit) begin
        scale_out  <= pend_scale;
        mirror_out <= pend_mirror;
      end
      // stage p0: window decision for the current pixel
      win_p0       <= win_comb;
      // stage p1: aligned with the address generator output
      in_frame_out <= win_p0;
    end
  end

endmodule

// File: tb/tb_view_ctrl.sv
// Directed bench for view_ctrl: a per-cycle reference model feeds a scoreboard queue for the
// two-cycle window flag and the committed configuration outputs.
module tb_view_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        btn_scale_in = 1'b0;
  logic        btn_mirror_in = 1'b0;
  logic [10:0] hcount_in = 11'd0;
  logic [9:0]  vcount_in = 10'd0;
  logic [1:0]  scale_out;
  logic        mirror_out, in_frame_out, commit_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] m_sc = 2'd0, p_sc = 2'd0;
  logic       m_mi = 1'b0, p_mi = 1'b0, m_cm = 1'b0;
  logic       prev_s = 1'b0, prev_m = 1'b0;
  logic       win_q[$];
`ifdef DEMO_CYCLE_EN
  int fc = 0;
`endif

  view_ctrl #(.H_ACTIVE(1024), .V_ACTIVE(768), .DEMO_FRAMES(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .btn_scale_in(btn_scale_in), .btn_mirror_in(btn_mirror_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .scale_out(scale_out), .mirror_out(mirror_out),
    .in_frame_out(in_frame_out), .commit_out(commit_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_win(input logic [1:0] sc, input int h, input int v);
    int hl, vl;
    case (sc)
      2'd0:    begin hl = 240; vl = 320; end
      2'd1:    begin hl = 480; vl = 640; end
      default: begin hl = 640; vl = 768; end
    endcase
    return (h < hl) && (v < vl) && (h < 1024) && (v < 768);
  endfunction

  // One clock: drive inputs, advance the model, then check outputs just after the edge.
  task automatic cyc(input int h, input int v, input int bs, input int bm, input int rst = 0);
    logic sp, mp, bnd;
    @(negedge clk_in);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    btn_scale_in  = (bs != 0);
    btn_mirror_in = (bm != 0);
    rst_in        = (rst != 0);
    bnd = (h == 0) && (v == 768);
    if (rst != 0) begin
      m_sc = 2'd0; m_mi = 1'b0; p_sc = 2'd0; p_mi = 1'b0; m_cm = 1'b0;
      prev_s = 1'b0; prev_m = 1'b0;
`ifdef DEMO_CYCLE_EN
      fc = 0;
`endif
      win_q.delete();
      win_q.push_back(1'b0);
      win_q.push_back(1'b0);
    end else begin
      win_q.push_back(exp_win(m_sc, h, v));
      sp = (bs != 0) && !prev_s;
      mp = (bm != 0) && !prev_m;
`ifdef DEMO_CYCLE_EN
      if (bnd) begin
        if (fc == 2) begin fc = 0; sp = 1'b1; end
        else fc++;
      end
`endif
      m_cm = bnd && ((p_sc != m_sc) || (p_mi != m_mi));
      if (m_cm) begin m_sc = p_sc; m_mi = p_mi; end
      if (sp) p_sc = (p_sc == 2'd2) ? 2'd0 : p_sc + 2'd1;
      if (mp) p_mi = !p_mi;
      prev_s = (bs != 0);
      prev_m = (bm != 0);
    end
    @(posedge clk_in);
    #1;
    chk("scale", scale_out, m_sc);
    chk("mirror", {1'b0, mirror_out}, {1'b0, m_mi});
    chk("commit", {1'b0, commit_out}, {1'b0, m_cm});
    if (win_q.size() >= 2) chk("in_frame", {1'b0, in_frame_out}, {1'b0, win_q.pop_front()});
  endtask

  // Sweep the window corners of every scale, a few off-screen points, then the boundary cycle.
  task automatic frame();
    int hs[9] = '{0, 100, 239, 240, 479, 480, 639, 640, 1023};
    int vs[6] = '{0, 319, 320, 639, 640, 767};
    for (int j = 0; j < 6; j++)
      for (int i = 0; i < 9; i++) cyc(hs[i], vs[j], 0, 0);
    cyc(1100, 100, 0, 0);
    cyc(100, 800, 0, 0);
    cyc(0, 768, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_scale", scale_out, 2'd0);
    chk("rst_mirror", {1'b0, mirror_out}, 2'd0);
    chk("rst_commit", {1'b0, commit_out}, 2'd0);
    chk("rst_in_frame", {1'b0, in_frame_out}, 2'd0);
    frame();
    frame();
`ifndef DEMO_CYCLE_EN
    chk("idle_scale", scale_out, 2'd0);

    // Held scale press: one step, visible only after the boundary
    cyc(100, 50, 1, 0); cyc(101, 50, 1, 0); cyc(102, 50, 0, 0);
    chk("hold_scale", scale_out, 2'd0);
    frame();
    chk("c1_scale", scale_out, 2'd1);
    chk("c1_pulse", {1'b0, commit_out}, 2'd1);
    cyc(1, 768, 0, 0);
    chk("c1_single", {1'b0, commit_out}, 2'd0);
    frame();

    // Three scale presses (one simultaneous with mirror) wrap back to 1x2 = scale 1
    cyc(10, 10, 1, 0); cyc(11, 10, 0, 0);
    cyc(12, 10, 1, 1); cyc(13, 10, 0, 0);
    cyc(14, 10, 1, 0); cyc(15, 10, 0, 0);
    frame();
    chk("acc_scale", scale_out, 2'd1);
    chk("acc_mirror", {1'b0, mirror_out}, 2'd1);
    chk("acc_pulse", {1'b0, commit_out}, 2'd1);

    // Two mirror presses cancel
    cyc(10, 10, 0, 1); cyc(11, 10, 0, 0);
    cyc(12, 10, 0, 1); cyc(13, 10, 0, 0);
    frame();
    chk("cancel_pulse", {1'b0, commit_out}, 2'd0);
    chk("cancel_mirror", {1'b0, mirror_out}, 2'd1);

    // Press on the boundary from IDLE
    cyc(0, 768, 1, 0);
    chk("bidle_scale", scale_out, 2'd1);
    chk("bidle_pulse", {1'b0, commit_out}, 2'd0);
    cyc(1, 768, 0, 0);
    frame();
    chk("bidle_next", scale_out, 2'd2);

    // Press on the boundary from PENDING: mirror commits now, scale next boundary
    cyc(20, 20, 0, 1); cyc(21, 20, 0, 0);
    cyc(0, 768, 1, 0);
    chk("bpend_mirror", {1'b0, mirror_out}, 2'd0);
    chk("bpend_scale", scale_out, 2'd2);
    chk("bpend_pulse", {1'b0, commit_out}, 2'd1);
    cyc(1, 768, 0, 0);
    frame();
    chk("bpend_next", scale_out, 2'd0);
    chk("bpend_next_pulse", {1'b0, commit_out}, 2'd1);

    // Reset while pending scale 2 discards the request
    cyc(30, 30, 1, 0); cyc(31, 30, 0, 0);
    cyc(32, 30, 1, 1); cyc(33, 30, 0, 0);
    cyc(34, 30, 0, 0, 1); cyc(35, 30, 0, 0, 1);
    chk("rst2_scale", scale_out, 2'd0);
    chk("rst2_in_frame", {1'b0, in_frame_out}, 2'd0);
    frame();
    chk("rst2_no_commit", {1'b0, commit_out}, 2'd0);
    chk("rst2_scale_kept", scale_out, 2'd0);
`else
    for (int k = 0; k < 7; k++) frame();
`endif
    frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
